mmss_timer_ctrl: RTL and testbench

Controller for a minutes:seconds timer built from cascaded BCD digit counters: two mod-10 units digits and two mod-6 tens digits. It has a tick prescaler and a run/pause/done state machine. It sequences direction, enable, load and clear of the digit chain, and gives the display path BCD MM:SS plus status. It replaces free-running direct clocking of the digit counters with a single synchronous controller.

---
 rtl/mmss_timer_pkg.sv | 16 +
 rtl/bcd_digit.sv | 34 +++
 rtl/mmss_timer_ctrl.sv | 128 ++++++++++++
 tb/tb_mmss_timer_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mmss_timer_pkg.sv
// rtl/mmss_timer_pkg.sv - shared types and digit limits for the MM:SS timer controller
package mmss_timer_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_FIN} state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t UNITS_MAX = 4'd9;
    localparam bcd_t TENS_MAX  = 4'd5;

    // One BCD byte of the display: [7:4] tens (0..5), [3:0] units (0..9)
    function automatic logic bcd_pair_ok(input logic [7:0] v);
        return (v[7:4] <= TENS_MAX) && (v[3:0] <= UNITS_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one up/down BCD digit with load and boundary carry/borrow
module bcd_digit
    import mmss_timer_pkg::*;
#(
    parameter bcd_t MAX = UNITS_MAX
) (
    input  logic       CP,
    input  logic       CLR,
    input  logic       EN,
    input  logic       UP,
    input  logic       LD,
    input  logic [3:0] D,
    output logic [3:0] Q,
    output logic       CO
);

    // Carry when counting up from MAX, borrow when counting down from 0
    assign CO = EN && (UP ? (Q == MAX) : (Q == 4'd0));

    always_ff @(posedge CP) begin
        if (CLR) begin
            Q <= 4'd0;
        end else if (LD) begin
            Q <= D;
        end else if (EN) begin
            if (UP) begin
                Q <= (Q == MAX) ? 4'd0 : Q + 4'd1;
            end else begin
                Q <= (Q == 4'd0) ? MAX : Q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/mmss_timer_ctrl.sv
// rtl/mmss_timer_ctrl.sv - run/pause/done controller, prescaler and BCD MM:SS digit chain
module mmss_timer_ctrl
    import mmss_timer_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       CP,
    input  logic       CLR,
    input  logic       START,
    input  logic       STOP,
    input  logic       U,
    input  logic       LOAD,
    input  logic [7:0] LD_M,
    input  logic [7:0] LD_S,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic       RUN,
    output logic       TICK,
    output logic       DONE,
    output logic       ERR
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_t        state, state_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic          dir, dir_nxt;
    logic          done_q, done_nxt;
    logic          err_q, err_nxt;

    logic tick, tick_en, ld_ok, load_go, start_go;
    logic at_max, at_zero, term_on_tick;
    logic c_su, c_st, c_mu, c_mt;
    bcd_t q_su, q_st, q_mu, q_mt;

    assign MIN  = {q_mt, q_mu};
    assign SEC  = {q_st, q_su};
    assign RUN  = (state == ST_RUN);
    assign TICK = tick;
    assign DONE = done_q;
    assign ERR  = err_q;

    assign at_max  = ({MIN, SEC} == 16'h5959);
    assign at_zero = ({MIN, SEC} == 16'h0000);
    assign tick    = (state == ST_RUN) && (pre == PW'(TICK_DIV - 1));

    // Saturate instead of wrapping if a tick ever lands on the terminal value
    assign tick_en      = tick && !(dir ? at_max : at_zero);
    assign term_on_tick = tick_en && (dir ? ({MIN, SEC} == 16'h5958)
                                          : ({MIN, SEC} == 16'h0001));

    assign ld_ok    = bcd_pair_ok(LD_M) && bcd_pair_ok(LD_S);
    assign load_go  = LOAD && (state != ST_RUN) && ld_ok;
    assign start_go = START && !STOP && !LOAD && (state != ST_RUN);

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre;
        dir_nxt   = dir;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_RUN: begin
                pre_nxt = tick ? '0 : pre + PW'(1);
                if (term_on_tick) begin
                    state_nxt = ST_FIN;
                    done_nxt  = 1'b1;
                end else if (STOP) begin
                    state_nxt = ST_PAUSE;
                end
            end
            default: begin
                if (LOAD) begin
                    err_nxt = !ld_ok;
                end else if (start_go) begin
                    dir_nxt = U;
                    // Resume from PAUSE keeps the partially elapsed second
                    if (state != ST_PAUSE) begin
                        pre_nxt = '0;
                    end
                    if (U ? at_max : at_zero) begin
                        state_nxt = ST_FIN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (CLR) begin
            state  <= ST_IDLE;
            pre    <= '0;
            dir    <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pre    <= pre_nxt;
            dir    <= dir_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    bcd_digit #(.MAX(UNITS_MAX)) u_sec_units (
        .CP(CP), .CLR(CLR), .EN(tick_en), .UP(dir), .LD(load_go),
        .D(LD_S[3:0]), .Q(q_su), .CO(c_su)
    );

    bcd_digit #(.MAX(TENS_MAX)) u_sec_tens (
        .CP(CP), .CLR(CLR), .EN(c_su), .UP(dir), .LD(load_go),
        .D(LD_S[7:4]), .Q(q_st), .CO(c_st)
    );

    bcd_digit #(.MAX(UNITS_MAX)) u_min_units (
        .CP(CP), .CLR(CLR), .EN(c_st), .UP(dir), .LD(load_go),
        .D(LD_M[3:0]), .Q(q_mu), .CO(c_mu)
    );

    bcd_digit #(.MAX(TENS_MAX)) u_min_tens (
        .CP(CP), .CLR(CLR), .EN(c_mu), .UP(dir), .LD(load_go),
        .D(LD_M[7:4]), .Q(q_mt), .CO(c_mt)
    );

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// tb/tb_mmss_timer_ctrl.sv - scoreboard bench for mmss_timer_ctrl with TICK_DIV=4
module tb_mmss_timer_ctrl;

    logic       CP = 1'b0;
    logic       CLR, START, STOP, U, LOAD;
    logic [7:0] LD_M, LD_S;
    logic [7:0] MIN, SEC;
    logic       RUN, TICK, DONE, ERR;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [2:0] P_TICK = 3'b100;
    localparam logic [2:0] P_DONE = 3'b010;
    localparam logic [2:0] P_ERR  = 3'b001;

    // {pulses, MIN, SEC, RUN, cycle}
    logic [51:0] sb[$];

    mmss_timer_ctrl #(.TICK_DIV(4)) dut (
        .CP(CP), .CLR(CLR), .START(START), .STOP(STOP), .U(U), .LOAD(LOAD),
        .LD_M(LD_M), .LD_S(LD_S), .MIN(MIN), .SEC(SEC), .RUN(RUN),
        .TICK(TICK), .DONE(DONE), .ERR(ERR)
    );

    always #5 CP = ~CP;
    always @(posedge CP) cyc <= cyc + 1;

    function automatic logic [51:0] ev(input logic [2:0] p, input logic [7:0] m,
                                       input logic [7:0] s, input logic r, input int c);
        return {p, m, s, r, 32'(c)};
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive(input logic clr, input logic st, input logic sp, input logic ld,
                         input logic u, input logic [7:0] m, input logic [7:0] s,
                         output int n);
        CLR = clr; START = st; STOP = sp; LOAD = ld; U = u; LD_M = m; LD_S = s;
        n = cyc + 1;
        @(negedge CP);
        CLR = 1'b0; START = 1'b0; STOP = 1'b0; LOAD = 1'b0;
    endtask

    initial begin
        logic [51:0] act, exp;
        forever begin
            @(negedge CP);
            if (TICK === 1'b1 || DONE === 1'b1 || ERR === 1'b1) begin
                act = ev({TICK, DONE, ERR}, MIN, SEC, RUN, cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 64'(act), 64'(0));
                end else begin
                    exp = sb.pop_front();
                    chk("pulse_event", 64'(act), 64'(exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int n, m, r, q, t, e;
        CLR = 1'b1; START = 1'b0; STOP = 1'b0; LOAD = 1'b0; U = 1'b0;
        LD_M = 8'h00; LD_S = 8'h00;
        @(negedge CP);
        @(negedge CP);
        CLR = 1'b0;
        chk("reset_state", 64'({MIN, SEC, RUN, TICK, DONE, ERR}), 64'(0));
        drive(0, 0, 0, 1, 0, 8'h12, 8'h34, e);
        chk("load_1234", 64'({MIN, SEC}), 64'h1234);
        drive(1, 0, 0, 0, 0, 8'h00, 8'h00, e);
        chk("clr_after_load", 64'({MIN, SEC, RUN, TICK, DONE, ERR}), 64'(0));

        // Countdown 01:02 -> 00:00, 62 ticks
        drive(0, 0, 0, 1, 0, 8'h01, 8'h02, e);
        n = cyc + 1;
        t = 62;
        for (int k = 1; k <= 62; k++) begin
            sb.push_back(ev(P_TICK, bcd2(t / 60), bcd2(t % 60), 1'b1, n + 4 * k - 1));
            t--;
        end
        sb.push_back(ev(P_DONE, 8'h00, 8'h00, 1'b0, n + 248));
        drive(0, 1, 0, 0, 0, 8'h00, 8'h00, e);
        while (cyc < n + 250) @(negedge CP);
        chk("countdown_fin", 64'({MIN, SEC, RUN}), 64'(0));
        sb.push_back(ev(P_DONE, 8'h00, 8'h00, 1'b0, cyc + 1));
        drive(0, 1, 0, 0, 0, 8'h00, 8'h00, e);

        // Count up and saturate at 59:59
        drive(0, 0, 0, 1, 0, 8'h59, 8'h58, e);
        n = cyc + 1;
        sb.push_back(ev(P_TICK, 8'h59, 8'h58, 1'b1, n + 3));
        sb.push_back(ev(P_DONE, 8'h59, 8'h59, 1'b0, n + 4));
        drive(0, 1, 0, 0, 1, 8'h00, 8'h00, e);
        repeat (12) @(negedge CP);
        chk("saturate_hold", 64'({MIN, SEC, RUN}), 64'({8'h59, 8'h59, 1'b0}));

        // Pause after two prescale cycles, resume keeps the phase
        drive(0, 0, 0, 1, 0, 8'h00, 8'h10, e);
        drive(0, 1, 0, 0, 1, 8'h00, 8'h00, n);
        @(negedge CP);
        drive(0, 0, 1, 0, 1, 8'h00, 8'h00, e);
        chk("stop_pauses", 64'({MIN, SEC, RUN}), 64'({8'h00, 8'h10, 1'b0}));
        repeat (10) @(negedge CP);
        m = cyc + 1;
        sb.push_back(ev(P_TICK, 8'h00, 8'h10, 1'b1, m + 1));
        drive(0, 1, 0, 0, 1, 8'h00, 8'h00, e);
        @(negedge CP);
        @(negedge CP);
        drive(0, 1, 1, 0, 1, 8'h00, 8'h00, e);
        chk("start_stop_same_cycle", 64'({MIN, SEC, RUN}), 64'({8'h00, 8'h11, 1'b0}));

        // Rejected loads: bad seconds tens, bad minutes units, bad minutes tens
        q = cyc + 1;
        sb.push_back(ev(P_ERR, 8'h00, 8'h11, 1'b0, q));
        drive(0, 0, 0, 1, 0, 8'h07, 8'h6A, e);
        q = cyc + 1;
        sb.push_back(ev(P_ERR, 8'h00, 8'h11, 1'b0, q));
        drive(0, 0, 0, 1, 0, 8'h0A, 8'h00, e);
        q = cyc + 1;
        sb.push_back(ev(P_ERR, 8'h00, 8'h11, 1'b0, q));
        drive(0, 1, 0, 1, 0, 8'h60, 8'h00, e);
        chk("rejected_keeps_digits", 64'({MIN, SEC, RUN}), 64'({8'h00, 8'h11, 1'b0}));

        // Resume with prescaler at 1; LOAD in RUN ignored; STOP on the tick edge
        r = cyc + 1;
        sb.push_back(ev(P_TICK, 8'h00, 8'h11, 1'b1, r + 2));
        drive(0, 1, 0, 0, 1, 8'h00, 8'h00, e);
        drive(0, 0, 0, 1, 0, 8'h00, 8'h00, e);
        chk("load_in_run_ignored", 64'({MIN, SEC, RUN}), 64'({8'h00, 8'h11, 1'b1}));
        @(negedge CP);
        drive(0, 0, 1, 0, 0, 8'h00, 8'h00, e);
        chk("stop_on_tick", 64'({MIN, SEC, RUN}), 64'({8'h00, 8'h12, 1'b0}));

        // LOAD beats START, then zero start finishes immediately
        drive(0, 1, 0, 1, 0, 8'h00, 8'h00, e);
        chk("load_beats_start", 64'({MIN, SEC, RUN}), 64'(0));
        sb.push_back(ev(P_DONE, 8'h00, 8'h00, 1'b0, cyc + 1));
        drive(0, 1, 0, 0, 0, 8'h00, 8'h00, e);
        repeat (6) @(negedge CP);

        // CLR while running
        drive(0, 0, 0, 1, 0, 8'h00, 8'h05, e);
        drive(0, 1, 0, 0, 1, 8'h00, 8'h00, e);
        chk("running_before_clr", 64'(RUN), 64'(1));
        repeat (2) @(negedge CP);
        drive(1, 0, 0, 0, 0, 8'h00, 8'h00, e);
        chk("clr_mid_run", 64'({MIN, SEC, RUN, TICK, DONE, ERR}), 64'(0));
        repeat (8) @(negedge CP);

        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
